// File: rtl/vending_pkg.sv
// Shared types and constants for the vending payout path.
// Coin values are expressed in nickel units so the datapath never sees cents.
package vending_pkg;

    localparam int CHANGE_W = 3;

    localparam logic [CHANGE_W-1:0] NICKEL_UNITS = 3'd1;
    localparam logic [CHANGE_W-1:0] DIME_UNITS   = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT_D,
        EJECT_N,
        DONE,
        FAULT
    } pay_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Vending-FSM and hopper signals of the change dispenser.
// The master side (vending FSM plus hoppers) drives the i_* signals; the dispenser drives o_*.
interface change_dispenser_if;
    import vending_pkg::*;

    logic                i_soda;
    logic [CHANGE_W-1:0] i_change;
    logic                i_dime_empty;
    logic                i_nickel_empty;
    logic                i_eject_ack;
    logic                o_dime_eject;
    logic                o_nickel_eject;
    logic                o_busy;
    logic                o_done;
    logic [CHANGE_W-1:0] o_owed;
    logic                o_fault;
    logic                o_overflow;

    modport master (
        output i_soda, i_change, i_dime_empty, i_nickel_empty, i_eject_ack,
        input  o_dime_eject, o_nickel_eject, o_busy, o_done, o_owed, o_fault, o_overflow
    );

    modport slave (
        input  i_soda, i_change, i_dime_empty, i_nickel_empty, i_eject_ack,
        output o_dime_eject, o_nickel_eject, o_busy, o_done, o_owed, o_fault, o_overflow
    );

endinterface

// File: rtl/eject_timer.sv
// Counts unacknowledged eject cycles; expired flags the cycle whose edge brings the count to ACK_TIMEOUT.
// Combinational expiry, one register stage of count; no backpressure.
module eject_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires one cycle early so the FSM leaves EJECT on the very edge the count hits the limit.
    assign expired = enable && (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change one coin at a time, dimes first, with a one-deep pending request slot.
// First eject two cycles after the strobe; hoppers pace the payout via ack, timeout turns a stall into a fault.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    change_dispenser_if.slave  bus
);

    pay_state_t          state, state_nxt;
    logic [CHANGE_W-1:0] owed, owed_nxt;
    logic                pend_vld, pend_vld_nxt;
    logic [CHANGE_W-1:0] pend_val, pend_val_nxt;
    logic                ovf, ovf_nxt;
    logic                in_eject;
    logic                expired;

    assign in_eject = (state == EJECT_D) || (state == EJECT_N);

    eject_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (!in_eject),
        .enable  (in_eject && !bus.i_eject_ack),
        .expired (expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            owed     <= '0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            owed     <= owed_nxt;
            pend_vld <= pend_vld_nxt;
            pend_val <= pend_val_nxt;
            ovf      <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owed_nxt     = owed;
        pend_vld_nxt = pend_vld;
        pend_val_nxt = pend_val;
        ovf_nxt      = ovf;

        if (bus.i_soda && (state == SELECT || state == EJECT_D || state == EJECT_N)) begin
            if (!pend_vld) begin
                pend_vld_nxt = 1'b1;
                pend_val_nxt = bus.i_change;
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (bus.i_soda) begin
                    owed_nxt  = bus.i_change;
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (owed == '0) begin
                    state_nxt = DONE;
                end else if (owed >= DIME_UNITS && !bus.i_dime_empty) begin
                    state_nxt = EJECT_D;
                end else if (owed >= NICKEL_UNITS && !bus.i_nickel_empty) begin
                    state_nxt = EJECT_N;
                end else begin
                    state_nxt = FAULT;
                end
            end
            EJECT_D: begin
                if (bus.i_eject_ack) begin
                    owed_nxt  = owed - DIME_UNITS;
                    state_nxt = SELECT;
                end else if (expired) begin
                    state_nxt = FAULT;
                end
            end
            EJECT_N: begin
                if (bus.i_eject_ack) begin
                    owed_nxt  = owed - NICKEL_UNITS;
                    state_nxt = SELECT;
                end else if (expired) begin
                    state_nxt = FAULT;
                end
            end
            DONE: begin
                // The slot drains here, so a strobe landing on DONE refills it rather than overflowing.
                if (pend_vld) begin
                    owed_nxt     = pend_val;
                    state_nxt    = SELECT;
                    pend_vld_nxt = bus.i_soda;
                    pend_val_nxt = bus.i_soda ? bus.i_change : '0;
                end else if (bus.i_soda) begin
                    owed_nxt  = bus.i_change;
                    state_nxt = SELECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_dime_eject   = (state == EJECT_D);
    assign bus.o_nickel_eject = (state == EJECT_N);
    assign bus.o_busy         = (state == SELECT) || in_eject || (state == DONE);
    assign bus.o_done         = (state == DONE);
    assign bus.o_owed         = owed;
    assign bus.o_fault        = (state == FAULT);
    assign bus.o_overflow     = ovf;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser: expected coin/done/fault events are queued per request
// and a separate monitor pops them as the DUT presents them.
module tb_change_dispenser;
    import vending_pkg::*;

    localparam int K_DIME  = 0;
    localparam int K_NICK  = 1;
    localparam int K_DONE  = 2;
    localparam int K_FAULT = 3;

    typedef struct {
        int kind;
        int owed;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   hsum = 0;
    int   done_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   no_ack = 1'b0;
    exp_t q[$];

    change_dispenser_if ifc ();

    change_dispenser #(
        .ACK_TIMEOUT (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int owed);
        exp_t e;
        e.kind = kind;
        e.owed = owed;
        q.push_back(e);
    endtask

    task automatic expect_event(input int kind, input int owed_now);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_owed", owed_now, e.owed);
        end
    endtask

    // Monitor: every eject rising edge, done pulse and fault onset consumes one scoreboard entry.
    initial begin : monitor
        bit pd, pn, pf;
        pd = 1'b0; pn = 1'b0; pf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pd = 1'b0; pn = 1'b0; pf = 1'b0;
            end else begin
                if (ifc.o_dime_eject && ifc.o_nickel_eject) check("both_ejects", 1, 0);
                if (ifc.o_dime_eject || ifc.o_nickel_eject) hsum++;
                if (ifc.o_dime_eject && !pd) begin
                    hsum++;
                    expect_event(K_DIME, int'(ifc.o_owed));
                end
                if (ifc.o_nickel_eject && !pn) begin
                    hsum++;
                    expect_event(K_NICK, int'(ifc.o_owed));
                end
                if (ifc.o_done) begin
                    done_cnt++;
                    expect_event(K_DONE, int'(ifc.o_owed));
                end
                if (ifc.o_fault && !pf) expect_event(K_FAULT, int'(ifc.o_owed));
                pd = ifc.o_dime_eject;
                pn = ifc.o_nickel_eject;
                pf = ifc.o_fault;
            end
        end
    end

    // Hopper model: acks a held request after a random 0..3 extra cycles.
    initial begin : hopper
        int cnt, dly;
        cnt = 0;
        dly = $urandom_range(0, 3);
        ifc.i_eject_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || ifc.i_eject_ack) begin
                ifc.i_eject_ack = 1'b0;
                cnt = 0;
            end else if ((ifc.o_dime_eject || ifc.o_nickel_eject) && !no_ack) begin
                if (cnt >= dly) begin
                    ifc.i_eject_ack = 1'b1;
                    cnt = 0;
                    dly = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        ifc.i_soda = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference: dimes only if the dime hopper has coins, nickels cover the rest, fault if nickels are needed but absent.
    task automatic run_payout(input int c, input bit de, input bit ne, output bit f);
        int k, t, nd, rem;
        nd  = de ? 0 : c / 2;
        rem = c - 2 * nd;
        f   = ne && (rem > 0);
        for (int i = 0; i < nd; i++) push(K_DIME, c - 2 * i);
        if (f) begin
            push(K_FAULT, rem);
        end else begin
            for (int j = 0; j < rem; j++) push(K_NICK, rem - j);
            push(K_DONE, 0);
        end

        ifc.i_dime_empty   = de;
        ifc.i_nickel_empty = ne;
        ifc.i_change       = 3'(c);
        ifc.i_soda         = 1'b1;
        k    = cyc;
        hsum = 0;
        @(negedge clk);
        ifc.i_soda = 1'b0;
        check("select_busy", ifc.o_busy, 1);
        check("select_owed", ifc.o_owed, c);
        check("select_no_eject", {ifc.o_dime_eject, ifc.o_nickel_eject}, 0);
        @(negedge clk);
        if (f && nd == 0)   check("fault_at_n2", ifc.o_fault, 1);
        else if (c == 0)    check("done_at_n2", ifc.o_done, 1);
        else if (nd > 0)    check("dime_at_n2", ifc.o_dime_eject, 1);
        else                check("nickel_at_n2", ifc.o_nickel_eject, 1);

        t = 0;
        while (!(ifc.o_done || ifc.o_fault) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("payout_finished", int'(t < 200), 1);
        if (!f) check("done_latency", cyc - k, 2 + hsum);
        else    check("fault_outputs", {ifc.o_busy, ifc.o_dime_eject, ifc.o_nickel_eject}, 0);
        check("no_overflow", ifc.o_overflow, 0);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin : stimulus
        bit f;
        int t;
        ifc.i_soda         = 1'b0;
        ifc.i_change       = '0;
        ifc.i_dime_empty   = 1'b0;
        ifc.i_nickel_empty = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {ifc.o_dime_eject, ifc.o_nickel_eject, ifc.o_busy, ifc.o_done,
                                ifc.o_owed, ifc.o_fault, ifc.o_overflow}, 0);

        run_payout(3, 1'b0, 1'b0, f);
        run_payout(4, 1'b1, 1'b0, f);
        run_payout(0, 1'b0, 1'b0, f);

        // Unpayable single nickel: fault is terminal and later strobes are ignored.
        run_payout(1, 1'b0, 1'b1, f);
        repeat (3) @(negedge clk);
        ifc.i_soda = 1'b1;
        ifc.i_change = 3'd2;
        @(negedge clk);
        ifc.i_soda = 1'b0;
        repeat (2) @(negedge clk);
        check("fault_held", ifc.o_fault, 1);
        check("fault_ignores_soda", {ifc.o_busy, ifc.o_overflow}, 0);
        do_reset();
        check("fault_cleared", ifc.o_fault, 0);
        ifc.i_nickel_empty = 1'b0;

        // Missing ack: request is held for exactly the timeout, then faults.
        no_ack = 1'b1;
        push(K_DIME, 2);
        push(K_FAULT, 2);
        ifc.i_change = 3'd2;
        ifc.i_soda = 1'b1;
        @(negedge clk);
        ifc.i_soda = 1'b0;
        t = 0;
        while (!ifc.o_dime_eject && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (ifc.o_dime_eject && t < 50) begin
            t++;
            @(negedge clk);
        end
        check("timeout_eject_cycles", t, 8);
        check("timeout_fault", ifc.o_fault, 1);
        no_ack = 1'b0;
        @(negedge clk);
        check("timeout_queue_drained", q.size(), 0);
        do_reset();

        // Three strobes back to back: first pays, second waits in the slot, third overflows.
        push(K_DIME, 2);
        push(K_DONE, 0);
        push(K_NICK, 1);
        push(K_DONE, 0);
        done_cnt = 0;
        ifc.i_soda = 1'b1;
        ifc.i_change = 3'd2;
        @(negedge clk);
        ifc.i_change = 3'd1;
        @(negedge clk);
        ifc.i_change = 3'd2;
        @(negedge clk);
        ifc.i_soda = 1'b0;
        t = 0;
        while (done_cnt < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("overflow_done_pulses", done_cnt, 2);
        check("overflow_flag", ifc.o_overflow, 1);
        check("overflow_idle", ifc.o_busy, 0);
        check("overflow_queue_drained", q.size(), 0);
        do_reset();
        check("overflow_cleared", ifc.o_overflow, 0);

        for (int i = 0; i < 30; i++) begin
            run_payout($urandom_range(0, 7), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), f);
            if (f) do_reset();
        end
        ifc.i_dime_empty   = 1'b0;
        ifc.i_nickel_empty = 1'b0;

        // Asynchronous reset in the middle of a dime request.
        no_ack = 1'b1;
        push(K_DIME, 4);
        ifc.i_change = 3'd4;
        ifc.i_soda = 1'b1;
        @(negedge clk);
        ifc.i_soda = 1'b0;
        t = 0;
        while (!ifc.o_dime_eject && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("midreset_eject_seen", ifc.o_dime_eject, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {ifc.o_dime_eject, ifc.o_busy, ifc.o_owed}, 0);
        @(negedge clk);
        q.delete();
        no_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_payout(0, 1'b0, 1'b0, f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
